bk_ctrl: RTL and testbench



---
 rtl/bk_pkg.sv | 12 +
 rtl/edge_rise.sv | 24 ++
 rtl/bk_ctrl.sv | 124 ++++++++++++
 tb/tb_bk_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types and defaults for the backup-RAM transfer sequencer.
package bk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam logic [23:0] TIMEOUT_DEF = 24'd12_000_000;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: samples d, then flags cur & ~prev.
module edge_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic cur;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur  <= 1'b0;
         prev <= 1'b0;
      end else begin
         cur  <= d;
         prev <= cur;
      end
   end

   assign rise = cur & ~prev;

endmodule

// File: rtl/bk_ctrl.sv
// Sequences SECTORS consecutive SD block transfers between NVRAM and the SD
// image on load/save/auto triggers, with per-edge timeout and dirty tracking.
module bk_ctrl
   import bk_pkg::*;
#(
   parameter int          SECTORS  = 64,
   parameter bit          AUTOSAVE = 1'b1,
   parameter logic [23:0] TIMEOUT  = TIMEOUT_DEF
) (
   input  logic        clk_sys,
   input  logic        RESET_n,
   input  logic        ena,
   input  logic        img_nz,
   input  logic        dl_done,
   input  logic        load_req,
   input  logic        save_req,
   input  logic        osd_open,
   input  logic        nvram_we,
   input  logic        sd_ack,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic        busy,
   output logic        loading,
   output logic        dirty,
   output logic        err
);

   localparam int LBA_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;
   localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(SECTORS - 1);

   state_t           state;
   logic [LBA_W-1:0] lba;
   logic [23:0]      tmr;
   logic             ack_q;
   logic             load_rise;
   logic             save_rise;
   logic             osd_rise;
   logic             go_load;
   logic             go_save;
   logic             ack_rise;
   logic             ack_fall;
   logic             timed_out;

   edge_rise u_load (.clk(clk_sys), .rst_n(RESET_n), .d(load_req & ena), .rise(load_rise));
   edge_rise u_save (.clk(clk_sys), .rst_n(RESET_n), .d(save_req & ena), .rise(save_rise));
   edge_rise u_osd  (.clk(clk_sys), .rst_n(RESET_n), .d(osd_open & ena), .rise(osd_rise));

   // Load outranks save; auto-load outranks the OSD load edge.
   assign go_load   = (dl_done & ena & img_nz) | load_rise;
   assign go_save   = save_rise | (osd_rise & dirty & AUTOSAVE);
   assign ack_rise  = sd_ack & ~ack_q;
   assign ack_fall  = ~sd_ack & ack_q;
   assign timed_out = (tmr >= TIMEOUT - 24'd1);
   assign sd_lba    = 32'(lba);

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state   <= IDLE;
         lba     <= '0;
         tmr     <= '0;
         ack_q   <= 1'b0;
         sd_rd   <= 1'b0;
         sd_wr   <= 1'b0;
         busy    <= 1'b0;
         loading <= 1'b0;
         dirty   <= 1'b0;
         err     <= 1'b0;
      end else begin
         ack_q <= sd_ack;
         case (state)
            IDLE: begin
               if (go_load || go_save) begin
                  state   <= REQ;
                  lba     <= '0;
                  tmr     <= '0;
                  sd_rd   <= go_load;
                  sd_wr   <= ~go_load;
                  busy    <= 1'b1;
                  loading <= go_load;
                  err     <= 1'b0;
                  if (!go_load) dirty <= 1'b0;
               end
            end
            REQ, XFER: begin
               if (state == REQ && ack_rise) begin
                  sd_rd <= 1'b0;
                  sd_wr <= 1'b0;
                  tmr   <= '0;
                  state <= XFER;
               end else if (state == XFER && ack_fall) begin
                  tmr <= '0;
                  if (lba == LAST_LBA) begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     loading <= 1'b0;
                     if (loading) dirty <= 1'b0;
                  end else begin
                     lba   <= lba + LBA_W'(1);
                     sd_rd <= loading;
                     sd_wr <= ~loading;
                     state <= REQ;
                  end
               end else if (timed_out) begin
                  // An aborted save leaves NVRAM unsaved, so mark it dirty again.
                  state   <= IDLE;
                  err     <= 1'b1;
                  sd_rd   <= 1'b0;
                  sd_wr   <= 1'b0;
                  busy    <= 1'b0;
                  loading <= 1'b0;
                  if (!loading) dirty <= 1'b1;
               end else begin
                  tmr <= tmr + 24'd1;
               end
            end
            default: state <= IDLE;
         endcase
         // Console writes win over the save-start clear in the same cycle.
         if (nvram_we && !loading) dirty <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bk_ctrl.sv
// Bench for bk_ctrl: trigger vector table plus random vectors, with an SD
// responder and hand sequences for drop, timeout and mid-transfer reset.
module tb_bk_ctrl;

   localparam int SECTORS = 64;

   logic        clk_sys = 1'b0;
   logic        RESET_n = 1'b0;
   logic        ena = 1'b1, img_nz = 1'b1, dl_done = 1'b0;
   logic        load_req = 1'b0, save_req = 1'b0, osd_open = 1'b0;
   logic        nvram_we = 1'b0, sd_ack = 1'b0;
   logic [31:0] sd_lba, na_sd_lba;
   logic        sd_rd, sd_wr, busy, loading, dirty, err;
   logic        na_sd_rd, na_sd_wr, na_busy, na_loading, na_dirty, na_err;

   int n_checks = 0;
   int n_fail   = 0;
   bit dirty_m  = 1'b0;
   bit dirty_na = 1'b0;

   typedef struct {
      string name;
      bit    ena, nz, dl, ld, sv, osd, we;
      int    exp_op;
      int    exp_na;
   } vec_t;

   vec_t tbl[8];

   bk_ctrl #(.SECTORS(SECTORS), .AUTOSAVE(1'b1), .TIMEOUT(24'd100)) dut (
      .clk_sys(clk_sys), .RESET_n(RESET_n), .ena(ena), .img_nz(img_nz),
      .dl_done(dl_done), .load_req(load_req), .save_req(save_req),
      .osd_open(osd_open), .nvram_we(nvram_we), .sd_ack(sd_ack),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .busy(busy),
      .loading(loading), .dirty(dirty), .err(err)
   );

   bk_ctrl #(.SECTORS(SECTORS), .AUTOSAVE(1'b0), .TIMEOUT(24'd100)) dut_na (
      .clk_sys(clk_sys), .RESET_n(RESET_n), .ena(ena), .img_nz(img_nz),
      .dl_done(dl_done), .load_req(load_req), .save_req(save_req),
      .osd_open(osd_open), .nvram_we(nvram_we), .sd_ack(sd_ack),
      .sd_lba(na_sd_lba), .sd_rd(na_sd_rd), .sd_wr(na_sd_wr), .busy(na_busy),
      .loading(na_loading), .dirty(na_dirty), .err(na_err)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(string name, bit e, bit nz, bit dl, bit ld, bit sv,
                               bit osd, bit we, int op, int na);
      vec_t v;
      v.name = name; v.ena = e; v.nz = nz; v.dl = dl; v.ld = ld; v.sv = sv;
      v.osd = osd; v.we = we; v.exp_op = op; v.exp_na = na;
      return v;
   endfunction

   // Reference: 0 = no transfer, 1 = load, 2 = save.
   function automatic int model_op(vec_t v, bit d, bit autosave);
      if (v.ena && v.dl && v.nz) return 1;
      if (v.ena && v.ld) return 1;
      if (v.ena && v.sv) return 2;
      if (v.ena && v.osd && d && autosave) return 2;
      return 0;
   endfunction

   task automatic pulse_we();
      nvram_we = 1'b1;
      @(negedge clk_sys);
      nvram_we = 1'b0;
   endtask

   // Levels rise, the dl_done pulse lands in the cycle the edges are seen.
   task automatic start_trigger(input bit l, input bit s, input bit o, input bit d);
      load_req = l; save_req = s; osd_open = o;
      @(negedge clk_sys);
      dl_done = d;
      @(negedge clk_sys);
      dl_done = 1'b0;
      load_req = 1'b0; save_req = 1'b0; osd_open = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (sd_rd || sd_wr) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_sys);
      end
   endtask

   task automatic run_xfer(input int op, input int first, input int last);
      bit ok;
      for (int s = first; s <= last; s++) begin
         wait_req(ok);
         check($sformatf("req_seen[%0d]", s), 32'(ok), 32'd1);
         if (!ok) break;
         check($sformatf("lba[%0d]", s), sd_lba, 32'(s));
         check($sformatf("rd[%0d]", s), 32'(sd_rd), 32'(op == 1));
         check($sformatf("wr[%0d]", s), 32'(sd_wr), 32'(op == 2));
         check($sformatf("loading[%0d]", s), 32'(loading), 32'(op == 1));
         check($sformatf("busy[%0d]", s), 32'(busy), 32'd1);
         repeat (10) @(negedge clk_sys);
         sd_ack = 1'b1;
         @(negedge clk_sys);
         check($sformatf("req_drop[%0d]", s), 32'(sd_rd | sd_wr), 32'd0);
         repeat (2) @(negedge clk_sys);
         sd_ack = 1'b0;
         @(negedge clk_sys);
         if (s == SECTORS - 1) begin
            check("busy_end", 32'(busy), 32'd0);
            check("loading_end", 32'(loading), 32'd0);
            check("req_end", 32'(sd_rd | sd_wr), 32'd0);
         end else begin
            check($sformatf("next_req[%0d]", s), 32'(sd_rd | sd_wr), 32'd1);
         end
      end
   endtask

   task automatic apply_vec(input vec_t v);
      bit dm, dn;
      ena = v.ena; img_nz = v.nz;
      if (v.we) pulse_we();
      dm = v.we ? 1'b1 : dirty_m;
      dn = v.we ? 1'b1 : dirty_na;
      start_trigger(v.ld, v.sv, v.osd, v.dl);
      check({v.name, "_rd"}, 32'(sd_rd), 32'(v.exp_op == 1));
      check({v.name, "_wr"}, 32'(sd_wr), 32'(v.exp_op == 2));
      check({v.name, "_busy"}, 32'(busy), 32'(v.exp_op != 0));
      check({v.name, "_na_rd"}, 32'(na_sd_rd), 32'(v.exp_na == 1));
      check({v.name, "_na_wr"}, 32'(na_sd_wr), 32'(v.exp_na == 2));
      check({v.name, "_dirty_start"}, 32'(dirty), 32'((v.exp_op == 2) ? 1'b0 : dm));
      if (v.exp_op != 0) begin
         run_xfer(v.exp_op, 0, SECTORS - 1);
      end else begin
         for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            check({v.name, "_idle"}, 32'(sd_rd | sd_wr | na_sd_rd | na_sd_wr), 32'd0);
         end
      end
      dirty_m  = (v.exp_op != 0) ? 1'b0 : dm;
      dirty_na = (v.exp_na != 0) ? 1'b0 : dn;
      check({v.name, "_dirty_end"}, 32'(dirty), 32'(dirty_m));
      check({v.name, "_na_dirty_end"}, 32'(na_dirty), 32'(dirty_na));
      ena = 1'b1; img_nz = 1'b1;
      repeat (3) @(negedge clk_sys);
   endtask

   initial begin
      vec_t v;
      //              name          ena nz dl ld sv osd we op na
      tbl[0] = mk("osd_clean",     1, 1, 0, 0, 0, 1, 0, 0, 0);
      tbl[1] = mk("osd_dirty",     1, 1, 0, 0, 0, 1, 1, 2, 0);
      tbl[2] = mk("autoload",      1, 1, 1, 0, 0, 0, 0, 1, 1);
      tbl[3] = mk("dl_and_save",   1, 1, 1, 0, 1, 0, 0, 1, 1);
      tbl[4] = mk("save_dirty",    1, 1, 0, 0, 1, 0, 1, 2, 2);
      tbl[5] = mk("dl_no_img",     1, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[6] = mk("load_no_ena",   0, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[7] = mk("osd_dirty_we",  1, 1, 0, 0, 0, 1, 1, 2, 0);

      repeat (3) @(negedge clk_sys);
      check("rst_lba", sd_lba, 32'd0);
      check("rst_rd", 32'(sd_rd), 32'd0);
      check("rst_wr", 32'(sd_wr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_loading", 32'(loading), 32'd0);
      check("rst_dirty", 32'(dirty), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      RESET_n = 1'b1;
      repeat (3) @(negedge clk_sys);

      for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

      for (int i = 0; i < 12; i++) begin
         v = mk($sformatf("rnd%0d", i), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0);
         v.exp_op = model_op(v, v.we ? 1'b1 : dirty_m, 1'b1);
         v.exp_na = model_op(v, v.we ? 1'b1 : dirty_na, 1'b0);
         apply_vec(v);
      end

      // Save edge during a load is dropped, not queued.
      start_trigger(1'b1, 1'b0, 1'b0, 1'b0);
      run_xfer(1, 0, 1);
      save_req = 1'b1;
      run_xfer(1, 2, SECTORS - 1);
      save_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_sys);
         check("drop_no_save", 32'(sd_rd | sd_wr), 32'd0);
      end

      // Ack withheld at sector 5.
      start_trigger(1'b1, 1'b0, 1'b0, 1'b0);
      run_xfer(1, 0, 4);
      check("to_lba", sd_lba, 32'd5);
      check("to_req", 32'(sd_rd), 32'd1);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk_sys);
         if (k == 99) check("to_err_early", 32'(err), 32'd0);
      end
      check("to_err", 32'(err), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      check("to_rd", 32'(sd_rd), 32'd0);
      check("to_loading", 32'(loading), 32'd0);
      repeat (3) @(negedge clk_sys);
      start_trigger(1'b1, 1'b0, 1'b0, 1'b0);
      check("to_err_clear", 32'(err), 32'd0);
      run_xfer(1, 0, SECTORS - 1);

      // Reset in the middle of a load.
      start_trigger(1'b1, 1'b0, 1'b0, 1'b0);
      run_xfer(1, 0, 29);
      check("rm_lba", sd_lba, 32'd30);
      #2;
      RESET_n = 1'b0;
      #1;
      check("rm_rd", 32'(sd_rd), 32'd0);
      check("rm_busy", 32'(busy), 32'd0);
      check("rm_loading", 32'(loading), 32'd0);
      check("rm_lba0", sd_lba, 32'd0);
      check("rm_dirty", 32'(dirty), 32'd0);
      @(negedge clk_sys);
      RESET_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("rm_idle", 32'(sd_rd | sd_wr | busy), 32'd0);
      start_trigger(1'b1, 1'b0, 1'b0, 1'b0);
      run_xfer(1, 0, SECTORS - 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
